// File: rtl/inst_buffer.sv
// Decoupling FIFO between Decode and the InstBufRename register: accepts 0-4
// decoded packets per cycle and releases them to Rename in groups of exactly 4.

`ifndef SIZE_SPECIAL_REG
`define SIZE_SPECIAL_REG 32
`endif
`ifndef LDST_TYPES_LOG
`define LDST_TYPES_LOG 2
`endif
`ifndef INST_TYPES_LOG
`define INST_TYPES_LOG 2
`endif
`ifndef SIZE_IMMEDIATE
`define SIZE_IMMEDIATE 16
`endif
`ifndef SIZE_RMT_LOG
`define SIZE_RMT_LOG 5
`endif
`ifndef SIZE_OPCODE_I
`define SIZE_OPCODE_I 8
`endif
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef SIZE_CTI_LOG
`define SIZE_CTI_LOG 2
`endif

module inst_buffer #(
  parameter int PKT_WIDTH = 2*`SIZE_SPECIAL_REG + 3 + `LDST_TYPES_LOG + `INST_TYPES_LOG +
                            `SIZE_IMMEDIATE + 1 + 3*`SIZE_RMT_LOG + 3 + `SIZE_OPCODE_I +
                            2*`SIZE_PC + `SIZE_CTI_LOG + 1,
  parameter int DEPTH     = 32,
  parameter int DEPTH_LOG = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic                 stall_i,
  input  logic                 decodeReady_i,
  input  logic [2:0]           decodeCount_i,
  input  logic [PKT_WIDTH-1:0] decodedPacket0_i,
  input  logic [PKT_WIDTH-1:0] decodedPacket1_i,
  input  logic [PKT_WIDTH-1:0] decodedPacket2_i,
  input  logic [PKT_WIDTH-1:0] decodedPacket3_i,
  output logic                 stallFetch_o,
  output logic                 instBufferReady_o,
  output logic [PKT_WIDTH-1:0] decodedPacket0_o,
  output logic [PKT_WIDTH-1:0] decodedPacket1_o,
  output logic [PKT_WIDTH-1:0] decodedPacket2_o,
  output logic [PKT_WIDTH-1:0] decodedPacket3_o,
  output logic [DEPTH_LOG:0]   instCount_o
);

  localparam logic [DEPTH_LOG:0] DEPTH_C = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [DEPTH_LOG:0] GROUP_C = (DEPTH_LOG+1)'(4);

  logic [PKT_WIDTH-1:0] mem_q [DEPTH];
  logic [PKT_WIDTH-1:0] lane_pkt [4];
  logic [DEPTH_LOG-1:0] head_q, head_d;
  logic [DEPTH_LOG-1:0] tail_q, tail_d;
  logic [DEPTH_LOG:0]   count_q, count_d;
  logic [2:0]           wr_n;
  logic                 wr_en;
  logic                 rd_en;

  assign lane_pkt[0] = decodedPacket0_i;
  assign lane_pkt[1] = decodedPacket1_i;
  assign lane_pkt[2] = decodedPacket2_i;
  assign lane_pkt[3] = decodedPacket3_i;

  assign wr_n = (decodeCount_i > 3'd4) ? 3'd4 : decodeCount_i;

  // Handshakes: Decode's bundle is taken on a cycle where decodeReady_i=1 and
  // stallFetch_o=0, otherwise Decode holds it; Rename takes the 4 output
  // packets on every cycle where instBufferReady_o=1. Both flags come from
  // registered occupancy, so the stall is conservative and never bypasses.
  assign stallFetch_o      = (DEPTH_C - count_q) < GROUP_C;
  assign instBufferReady_o = (count_q >= GROUP_C) && !stall_i;
  assign wr_en             = decodeReady_i && !stallFetch_o;
  assign rd_en             = instBufferReady_o;
  assign instCount_o       = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) tail_d = tail_q + DEPTH_LOG'(wr_n);
      if (rd_en) head_d = head_q + DEPTH_LOG'(4);
      count_d = count_q + (wr_en ? (DEPTH_LOG+1)'(wr_n) : '0) - (rd_en ? GROUP_C : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; pointer wrap handles bundles that straddle the end.
  always_ff @(posedge clk) begin
    if (reset && !flush_i && wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (i < int'(wr_n)) mem_q[tail_q + DEPTH_LOG'(i)] <= lane_pkt[i];
      end
    end
  end

  assign decodedPacket0_o = mem_q[head_q];
  assign decodedPacket1_o = mem_q[head_q + DEPTH_LOG'(1)];
  assign decodedPacket2_o = mem_q[head_q + DEPTH_LOG'(2)];
  assign decodedPacket3_o = mem_q[head_q + DEPTH_LOG'(3)];

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: an occupancy model plus an expected-packet
// queue that is filled on accepted writes and drained on each group release.

module tb_inst_buffer;

  localparam int W     = 16;
  localparam int DEPTH = 32;
  localparam int DLOG  = 5;

  logic            clk;
  logic            reset;
  logic            flush_i;
  logic            stall_i;
  logic            decodeReady_i;
  logic [2:0]      decodeCount_i;
  logic [W-1:0]    pkt_in [4];
  logic            stallFetch_o;
  logic            instBufferReady_o;
  logic [W-1:0]    pkt_out [4];
  logic [DLOG:0]   instCount_o;

  inst_buffer #(.PKT_WIDTH(W), .DEPTH(DEPTH), .DEPTH_LOG(DLOG)) dut (
    .clk               (clk),
    .reset             (reset),
    .flush_i           (flush_i),
    .stall_i           (stall_i),
    .decodeReady_i     (decodeReady_i),
    .decodeCount_i     (decodeCount_i),
    .decodedPacket0_i  (pkt_in[0]),
    .decodedPacket1_i  (pkt_in[1]),
    .decodedPacket2_i  (pkt_in[2]),
    .decodedPacket3_i  (pkt_in[3]),
    .stallFetch_o      (stallFetch_o),
    .instBufferReady_o (instBufferReady_o),
    .decodedPacket0_o  (pkt_out[0]),
    .decodedPacket1_o  (pkt_out[1]),
    .decodedPacket2_o  (pkt_out[2]),
    .decodedPacket3_o  (pkt_out[3]),
    .instCount_o       (instCount_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int           mdl_cnt = 0;
  int           n_pass  = 0;
  int           n_total = 0;
  int           seq     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs just after negedge, check the
  // registered-state outputs, update the model, then advance to next negedge.
  task automatic step(input logic rst_n, input logic fl, input logic st,
                      input logic dv, input int cnt);
    logic exp_rdy, exp_sf;
    int   n;
    reset         = rst_n;
    flush_i       = fl;
    stall_i       = st;
    decodeReady_i = dv;
    decodeCount_i = 3'(cnt);
    for (int i = 0; i < 4; i++) begin
      pkt_in[i] = {8'(seq + i), 8'($urandom_range(0, 255))};
    end
    seq = seq + 4;
    #1;
    exp_rdy = (mdl_cnt >= 4) && !st;
    exp_sf  = (DEPTH - mdl_cnt) < 4;
    chk("count", 32'(instCount_o), 32'(mdl_cnt));
    chk("ready", 32'(instBufferReady_o), 32'(exp_rdy));
    chk("stall_fetch", 32'(stallFetch_o), 32'(exp_sf));
    chk("count_bound", 32'(instCount_o <= DLOG'(0) + (DLOG+1)'(DEPTH)), 32'd1);
    if (exp_rdy && exp_q.size() >= 4) begin
      for (int k = 0; k < 4; k++) chk($sformatf("pkt%0d", k), 32'(pkt_out[k]), 32'(exp_q[k]));
    end else if (exp_rdy) begin
      chk("queue_underrun", 32'(exp_q.size()), 32'd4);
    end
    if (!rst_n || fl) begin
      exp_q.delete();
      mdl_cnt = 0;
    end else begin
      if (exp_rdy && exp_q.size() >= 4) begin
        for (int k = 0; k < 4; k++) void'(exp_q.pop_front());
        mdl_cnt = mdl_cnt - 4;
      end
      n = (cnt > 4) ? 4 : cnt;
      if (dv && !exp_sf) begin
        for (int i = 0; i < n; i++) exp_q.push_back(pkt_in[i]);
        mdl_cnt = mdl_cnt + n;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
    decodeReady_i = 1'b0; decodeCount_i = 3'd0;
    for (int i = 0; i < 4; i++) pkt_in[i] = '0;
    @(negedge clk);

    // Reset held two cycles with a full bundle offered, then first bundle
    step(0, 0, 0, 1, 4);
    step(0, 0, 0, 1, 4);
    step(1, 0, 0, 1, 4);
    step(1, 0, 0, 0, 0);

    // Uneven bundles 3,1,2,2 released in program order
    step(1, 0, 0, 1, 3);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 2);
    step(1, 0, 0, 1, 2);
    step(1, 0, 0, 0, 0);
    // Oversized count is clamped to 4
    step(1, 0, 0, 1, 7);
    step(1, 0, 0, 0, 0);

    // Stalled fill to exactly DEPTH, blocked writes, then drain
    for (int i = 0; i < 8; i++) step(1, 0, 1, 1, 4);
    step(1, 0, 1, 1, 4);
    step(1, 0, 0, 1, 4);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0);

    // Count DEPTH-3: conservative stall even with a read pending
    for (int i = 0; i < 7; i++) step(1, 0, 1, 1, 4);
    step(1, 0, 1, 1, 1);
    step(1, 0, 0, 1, 4);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 3);
    step(1, 0, 0, 0, 0);

    // Wrap: flush, stream to head=tail=28, then writes straddling the end
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 1, 4);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 2);
    step(1, 0, 0, 1, 4);
    step(1, 0, 0, 1, 2);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Flush at count 12 with a same-cycle write and read
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 4);
    step(1, 1, 0, 1, 4);
    step(1, 0, 0, 1, 4);
    step(1, 0, 0, 0, 0);

    // Steady state at count 8: write 4 and read 4 every cycle
    step(1, 0, 1, 1, 4);
    step(1, 0, 1, 1, 4);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 1, 4);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Random mix, then reset mid-stream
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), $urandom_range(0, 7));
    end
    step(0, 0, 0, 1, 4);
    step(1, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
